reg_file_2w2r: RTL and testbench
================================

Name: reg_file_2w2r

Overview:
- Parametrised successor to the single-write-port register file.
- Two write ports and two asynchronous read ports, with register 0 hardwired to zero.
- Optional write-to-read bypass.
- A reset-initialisation sequencer walks every entry after reset, loading zero or a per-register preset (stack and global pointers). This replaces per-entry reset logic.
- Sits in the decode stage of a dual-issue RISC-V core, between the writeback arbiter and the operand muxes.

Parameters:
- DWIDTH, 32, data width of each register.
- MDEPTH, 32, number of registers; power of two, at least 4.
- AWIDTH, 5, address width; equals log2(MDEPTH).
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to the read data; when 0 reads return the stored value.
- SP_INIT, 32'h0000_0F00, value loaded into register 2 by the init sequence.
- GP_INIT, 32'h0000_0100, value loaded into register 3 by the init sequence.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTN  input  1  reset, synchronous, active-low.
- WE0  input  1  write enable, port 0.
- WA0  input  AWIDTH  write address, port 0.
- WD0  input  DWIDTH  write data, port 0.
- WE1  input  1  write enable, port 1.
- WA1  input  AWIDTH  write address, port 1.
- WD1  input  DWIDTH  write data, port 1.
- RA1  input  AWIDTH  read address 1.
- RA2  input  AWIDTH  read address 2.
- RD1  output  DWIDTH  read data 1, combinational.
- RD2  output  DWIDTH  read data 2, combinational.
- BUSY  output  1  high while the init sequence runs; writes are ignored while high.

Behaviour:
- Clock/reset: one clock, CLK. Reset RSTN is synchronous and active-low, sampled only on the CLK rising edge.
- States: INIT and RUN; 5-bit (AWIDTH) counter CNT.
- Reset: a rising edge with RSTN=0 forces state=INIT, CNT=0, BUSY=1. No array entry is written on that edge. BUSY's reset value is 1.
- INIT, on each edge with RSTN=1:
  - RF[CNT] <= SP_INIT if CNT==2; GP_INIT if CNT==3; else 0.
  - If CNT==MDEPTH-1, go to RUN; else CNT++.
  - BUSY drops after exactly MDEPTH edges with RSTN high following reset release.
- Reset mid-INIT or mid-RUN: restarts at CNT=0. Entries already written keep their values until rewritten.
- INIT ignores WE0 and WE1 entirely; in-flight writebacks are dropped.
- BUSY is registered and equals (state==INIT).
- RUN, on each edge:
  - If WE0 and WA0!=0, RF[WA0] <= WD0.
  - If WE1 and WA1!=0, RF[WA1] <= WD1.
- Write collision: if both ports are enabled with WA0==WA1 (nonzero), port 1 wins. Port 1 is the younger instruction.
- Register 0: writes to address 0 are discarded on both ports. RD for address 0 is always 0, in every state and regardless of bypass.
- Reads: combinational from address to data, zero cycles latency.
  - While BUSY=1, RD1 and RD2 read 0.
  - Otherwise, with BYPASS=1 and RA nonzero:
    - RA==WA1 with WE1 gives WD1.
    - Else RA==WA0 with WE0 gives WD0.
    - Else RF[RA].
  - With BYPASS=0, RD = RF[RA]; the new value is visible the cycle after the write edge.
- Width rules: no arithmetic on data. Addresses at or above MDEPTH cannot occur because AWIDTH = log2(MDEPTH).
- Power-up: array and state are undefined until the first reset edge. Bench must reset first.

Test Plan:
- Init sequence: hold RSTN=0 for 2 edges, release, read all addresses each cycle -> BUSY=1 and RD=0 throughout. After exactly 32 edges BUSY=0, then RD(2)=0x00000F00, RD(3)=0x00000100, all other addresses 0.
- Dual write: in RUN, WE0=1, WA0=5, WD0=0xDEADBEEF; WE1=1, WA1=6, WD1=0x12345678 in one cycle -> next cycle RA1=5 gives 0xDEADBEEF and RA2=6 gives 0x12345678.
- Collision and x0: both ports write addr 7 (WD0=0xAAAA0000, WD1=0x5555FFFF) -> RD(7)=0x5555FFFF. Then WE0=1, WA0=0, WD0=0xFFFFFFFF -> RD(0)=0.
- Bypass: BYPASS=1, WE1=1, WA1=9, WD1=0xCAFEF00D, RA1=9 in the same cycle -> RD1=0xCAFEF00D combinationally. Repeat with BYPASS=0 -> RD1 shows the old value that cycle and 0xCAFEF00D the next.
- Mid-INIT reset and dropped writes: reset, release, after 10 edges drop RSTN for 1 edge -> CNT restarts and BUSY stays high for a further 32 edges. A WE0 write to addr 4 with 0x1 during INIT -> RD(4)=0 after BUSY falls.
- Mid-RUN reset: write 0x77 to addr 2, then assert RSTN=0 -> after re-init RD(2)=0x00000F00.

Source files
------------

// File: rtl/reg_file_2w2r.sv
// Dual-write, dual-read register file with x0 hardwired to zero, optional
// write-to-read bypass and a post-reset sequencer that initialises every entry.
module reg_file_2w2r #(
  parameter int unsigned       DWIDTH  = 32,
  parameter int unsigned       MDEPTH  = 32,
  parameter int unsigned       AWIDTH  = 5,
  parameter bit                BYPASS  = 1'b1,
  parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(32'h0000_0F00),
  parameter logic [DWIDTH-1:0] GP_INIT = DWIDTH'(32'h0000_0100)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              WE0,
  input  logic [AWIDTH-1:0] WA0,
  input  logic [DWIDTH-1:0] WD0,
  input  logic              WE1,
  input  logic [AWIDTH-1:0] WA1,
  input  logic [DWIDTH-1:0] WD1,
  input  logic [AWIDTH-1:0] RA1,
  input  logic [AWIDTH-1:0] RA2,
  output logic [DWIDTH-1:0] RD1,
  output logic [DWIDTH-1:0] RD2,
  output logic              BUSY
);

  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(MDEPTH - 1);
  localparam logic [AWIDTH-1:0] SP_IDX   = AWIDTH'(2);
  localparam logic [AWIDTH-1:0] GP_IDX   = AWIDTH'(3);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DWIDTH-1:0]   rf_q [MDEPTH];

  logic                init_we_c;
  logic [DWIDTH-1:0]   init_wd_c;
  logic                we0_c;
  logic                we1_c;

  // State register; entries are never touched on a reset edge
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: walk every entry once, then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1);
        end
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
    busy_d = (state_d == ST_INIT);
  end

  // Outputs: array write controls and combinational read ports
  always_comb begin
    init_we_c = 1'b0;
    init_wd_c = '0;
    we0_c     = 1'b0;
    we1_c     = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we_c = 1'b1;
        if (cnt_q == SP_IDX) begin
          init_wd_c = SP_INIT;
        end else if (cnt_q == GP_IDX) begin
          init_wd_c = GP_INIT;
        end
      end
      ST_RUN: begin
        we0_c = WE0 && (WA0 != '0);
        we1_c = WE1 && (WA1 != '0);
      end
      default: ;
    endcase

    // Port 1 is the younger writer, so it takes priority on the bypass path
    RD1 = '0;
    if (!busy_q && (RA1 != '0)) begin
      if (BYPASS && WE1 && (WA1 == RA1)) begin
        RD1 = WD1;
      end else if (BYPASS && WE0 && (WA0 == RA1)) begin
        RD1 = WD0;
      end else begin
        RD1 = rf_q[RA1];
      end
    end

    RD2 = '0;
    if (!busy_q && (RA2 != '0)) begin
      if (BYPASS && WE1 && (WA1 == RA2)) begin
        RD2 = WD1;
      end else if (BYPASS && WE0 && (WA0 == RA2)) begin
        RD2 = WD0;
      end else begin
        RD2 = rf_q[RA2];
      end
    end
  end

  // Storage array; port 1 is written last so it wins an address collision
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      if (init_we_c) begin
        rf_q[cnt_q] <= init_wd_c;
      end
      if (we0_c) begin
        rf_q[WA0] <= WD0;
      end
      if (we1_c) begin
        rf_q[WA1] <= WD1;
      end
    end
  end

  assign BUSY = busy_q;

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Bench for reg_file_2w2r: a bypassing and a non-bypassing instance share stimulus
// and are checked against hand vectors and an array-based reference model.
module tb_reg_file_2w2r;

  logic        clk = 1'b0;
  logic        rstn;
  logic        we0, we1;
  logic [4:0]  wa0, wa1, ra1, ra2;
  logic [31:0] wd0, wd1;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy_b, busy_n;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] mem [32];
  int          init_done;

  always #5 clk = ~clk;

  reg_file_2w2r #(.BYPASS(1'b1)) dut_b (
    .CLK(clk), .RSTN(rstn),
    .WE0(we0), .WA0(wa0), .WD0(wd0),
    .WE1(we1), .WA1(wa1), .WD1(wd1),
    .RA1(ra1), .RA2(ra2), .RD1(rd1_b), .RD2(rd2_b), .BUSY(busy_b)
  );

  reg_file_2w2r #(.BYPASS(1'b0)) dut_n (
    .CLK(clk), .RSTN(rstn),
    .WE0(we0), .WA0(wa0), .WD0(wd0),
    .WE1(we1), .WA1(wa1), .WD1(wd1),
    .RA1(ra1), .RA2(ra2), .RD1(rd1_n), .RD2(rd2_n), .BUSY(busy_n)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] b1, b2, n1, n2;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] preset(input int idx);
    if (idx == 2) return 32'h0000_0F00;
    if (idx == 3) return 32'h0000_0100;
    return 32'h0;
  endfunction

  function automatic logic model_busy();
    return init_done < 32;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] ra, input bit byp);
    if (model_busy() || ra == 5'd0) return 32'h0;
    if (byp && we1 && wa1 == ra) return wd1;
    if (byp && we0 && wa0 == ra) return wd0;
    return mem[ra];
  endfunction

  // Apply one rising edge to the model using the inputs currently driven
  task automatic model_edge();
    if (!rstn) begin
      init_done = 0;
    end else if (model_busy()) begin
      mem[init_done] = preset(init_done);
      init_done++;
    end else begin
      if (we0 && wa0 != 5'd0) mem[wa0] = wd0;
      if (we1 && wa1 != 5'd0) mem[wa1] = wd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'(model_busy()));
    chk({tag, "_busy_n"}, 32'(busy_n), 32'(model_busy()));
    chk({tag, "_rd1_b"}, rd1_b, model_rd(ra1, 1'b1));
    chk({tag, "_rd2_b"}, rd2_b, model_rd(ra2, 1'b1));
    chk({tag, "_rd1_n"}, rd1_n, model_rd(ra1, 1'b0));
    chk({tag, "_rd2_n"}, rd2_n, model_rd(ra2, 1'b0));
  endtask

  initial begin
    init_done = 0;
    // we0 wa0 wd0 we1 wa1 wd1 ra1 ra2 | bypass rd1 rd2 | no-bypass rd1 rd2
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd6,  32'h12345678, 5'd2,  5'd3,
                32'h00000F00, 32'h00000100, 32'h00000F00, 32'h00000100};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,
                32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
    vecs[2] = '{1'b1, 5'd7,  32'hAAAA0000, 1'b1, 5'd7,  32'h5555FFFF, 5'd7,  5'd0,
                32'h5555FFFF, 32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd5,
                32'h5555FFFF, 32'hDEADBEEF, 32'h5555FFFF, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,
                32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd7,
                32'h0,        32'h5555FFFF, 32'h0,        32'h5555FFFF};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hCAFEF00D, 5'd9,  5'd9,
                32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd9,
                32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[8] = '{1'b1, 5'd10, 32'h11111111, 1'b1, 5'd11, 32'h22222222, 5'd10, 5'd11,
                32'h11111111, 32'h22222222, 32'h0,        32'h0};
    vecs[9] = '{1'b1, 5'd12, 32'hAAAAAAAA, 1'b0, 5'd0,  32'h0,        5'd12, 5'd10,
                32'hAAAAAAAA, 32'h11111111, 32'h0,        32'h11111111};

    // Reset held for two edges, then a full init with a write attempt to x4
    idle(); ra1 = '0; ra2 = '0; rstn = 1'b0;
    #2;
    tick(); tick();
    chk("reset_busy_b", 32'(busy_b), 32'd1);
    chk("reset_busy_n", 32'(busy_n), 32'd1);
    rstn = 1'b1;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1;
    for (int k = 0; k < 32; k++) begin
      ra1 = 5'(k); ra2 = 5'(31 - k);
      #1;
      chk("init_busy", 32'(busy_b), 32'd1);
      chk("init_rd1", rd1_b, 32'h0);
      chk("init_rd2", rd2_n, 32'h0);
      tick();
    end
    idle();
    #1;
    chk("init_done_busy_b", 32'(busy_b), 32'd0);
    chk("init_done_busy_n", 32'(busy_n), 32'd0);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a);
      #1;
      chk("preset_b", rd1_b, preset(a));
      chk("preset_n", rd2_n, preset(a));
    end

    // Directed RUN vectors
    for (int i = 0; i < 10; i++) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      chk($sformatf("vec%0d_rd1_b", i), rd1_b, vecs[i].b1);
      chk($sformatf("vec%0d_rd2_b", i), rd2_b, vecs[i].b2);
      chk($sformatf("vec%0d_rd1_n", i), rd1_n, vecs[i].n1);
      chk($sformatf("vec%0d_rd2_n", i), rd2_n, vecs[i].n2);
      check_model($sformatf("vec%0d", i));
      tick();
    end
    idle();

    // Mid-INIT reset restarts the walk; writes during INIT are dropped
    rstn = 1'b0; tick(); rstn = 1'b1;
    repeat (10) tick();
    rstn = 1'b0; tick(); rstn = 1'b1;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1; ra1 = 5'd4; ra2 = 5'd2;
    for (int k = 0; k < 32; k++) begin
      #1;
      chk("restart_busy", 32'(busy_b), 32'd1);
      tick();
    end
    idle();
    #1;
    chk("restart_done_busy", 32'(busy_b), 32'd0);
    chk("dropped_write_x4", rd1_b, 32'h0);
    chk("restart_sp", rd2_n, 32'h00000F00);

    // Mid-RUN reset restores the stack-pointer preset
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h77; tick();
    idle(); ra1 = 5'd2;
    #1;
    chk("run_write_x2", rd1_n, 32'h77);
    rstn = 1'b0; tick(); rstn = 1'b1;
    repeat (32) tick();
    #1;
    chk("rerun_busy", 32'(busy_n), 32'd0);
    chk("rerun_sp", rd1_n, 32'h00000F00);

    // Randomised traffic with occasional resets, checked against the model
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 149) != 0);
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 31)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      wd1 = $urandom;
      ra1 = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 1) == 0) ? wa0 : 5'($urandom_range(0, 31));
      #1;
      check_model("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
